// File: rtl/dbg_halt_seq_pkg.sv
// Hold-protocol codes shared with the pipeline controller, plus the debug-halt
// state encoding and quiescence helper used by dbg_halt_seq.
`ifndef DBG_HALT_SEQ_DEFINES
`define DBG_HALT_SEQ_DEFINES
`define Hold_Flag_Bus  2:0
`define Hold_None      3'b000
`define Hold_Pc        3'b001
`define Hold_If        3'b010
`define Hold_Id        3'b011
`define HoldEnable     1'b1
`define HoldDisable    1'b0
`define DbgSt_Idle     2'b00
`define DbgSt_Req      2'b01
`define DbgSt_Halted   2'b10
`define DbgSt_Resume   2'b11
`endif

package dbg_halt_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = `DbgSt_Idle,
        ST_REQ    = `DbgSt_Req,
        ST_HALTED = `DbgSt_Halted,
        ST_RESUME = `DbgSt_Resume
    } dbg_state_e;

    localparam int DRAIN_W = 4;
    localparam int TMO_W   = 8;
    localparam int DLY_W   = 4;

    // The core is quiescent once the controller holds up to ID and nothing is in flight.
    function automatic logic is_quiescent(
        input logic [`Hold_Flag_Bus] hold,
        input logic                  jump,
        input logic                  busy
    );
        return (hold == `Hold_Id) && !jump && !busy;
    endfunction

endpackage

// File: rtl/dbg_halt_seq_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] LP_MAX = {W{1'b1}};
    localparam logic [W-1:0] LP_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_cnt;

    // Counter register: holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LP_MAX)) begin
            r_cnt <= r_cnt + LP_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/dbg_halt_seq.sv
// Debug halt requester: converts halt/resume pulses into a level hold request,
// waits for the core to drain, and acknowledges halt/resume to the debug module.
module dbg_halt_seq
    import dbg_halt_seq_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int TIMEOUT      = 64,
    parameter int RESUME_DELAY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt_req_i,
    input  logic                  resume_req_i,
    input  logic [`Hold_Flag_Bus] hold_flag_i,
    input  logic                  jump_flag_i,
    input  logic                  rib_busy_i,
    output logic                  halt_flag_o,
    output logic                  halted_o,
    output logic                  halt_ack_o,
    output logic                  resume_ack_o,
    output logic                  timeout_err_o,
    output logic [1:0]            state_o
);

    localparam logic [DRAIN_W-1:0] LP_DRAIN = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [TMO_W-1:0]   LP_TMO   = TMO_W'(TIMEOUT);
    localparam logic [DLY_W:0]     LP_DLY   = (DLY_W + 1)'(RESUME_DELAY);
    localparam logic [DLY_W:0]     LP_ONE   = {{DLY_W{1'b0}}, 1'b1};

    dbg_state_e          r_state;
    dbg_state_e          w_next;
    logic                w_quiet;
    logic                w_enter;
    logic                w_timeout;
    logic                w_halt_done;
    logic                w_resume_done;
    logic                w_drain_clr;
    logic                w_drain_inc;
    logic                w_tmo_clr;
    logic                w_tmo_inc;
    logic                w_dly_clr;
    logic                w_dly_inc;
    logic [DRAIN_W-1:0]  w_drain_cnt;
    logic [TMO_W-1:0]    w_tmo_cnt;
    logic [DLY_W-1:0]    w_dly_cnt;

    logic                r_pend;
    logic                r_halt_flag;
    logic                r_halted;
    logic                r_halt_ack;
    logic                r_resume_ack;
    logic                r_tmo_err;

    assign w_quiet = is_quiescent(hold_flag_i, jump_flag_i, rib_busy_i);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. In REQ an abort beats a completed drain, which beats a timeout.
    always_comb begin
        w_next        = r_state;
        w_timeout     = 1'b0;
        w_halt_done   = 1'b0;
        w_resume_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (halt_req_i) begin
                    w_next = ST_REQ;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (resume_req_i) begin
                    w_next = ST_IDLE;
                end else if (w_drain_cnt >= LP_DRAIN) begin
                    w_next      = ST_HALTED;
                    w_halt_done = 1'b1;
                end else if (w_tmo_cnt >= LP_TMO) begin
                    w_next    = ST_IDLE;
                    w_timeout = 1'b1;
                end else begin
                    w_next = ST_REQ;
                end
            end
            ST_HALTED: begin
                if (resume_req_i) begin
                    w_next = ST_RESUME;
                end else begin
                    w_next = ST_HALTED;
                end
            end
            ST_RESUME: begin
                // A zero delay still spends one cycle here so the hold drops before the ack.
                if (({1'b0, w_dly_cnt} + LP_ONE) >= LP_DLY) begin
                    w_resume_done = 1'b1;
                    if (r_pend || halt_req_i) begin
                        w_next = ST_REQ;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end else begin
                    w_next = ST_RESUME;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Counter controls: every state change restarts all counters.
    always_comb begin
        w_enter     = (w_next != r_state);
        w_drain_inc = (r_state == ST_REQ) && w_quiet;
        w_drain_clr = w_enter || (r_state != ST_REQ) || !w_quiet;
        w_tmo_inc   = (r_state == ST_REQ);
        w_tmo_clr   = w_enter || (r_state != ST_REQ);
        w_dly_inc   = (r_state == ST_RESUME);
        w_dly_clr   = w_enter || (r_state != ST_RESUME);
    end

    sat_cnt #(.W(DRAIN_W)) u_drain_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_drain_clr),
        .i_inc (w_drain_inc),
        .o_cnt (w_drain_cnt)
    );

    sat_cnt #(.W(TMO_W)) u_tmo_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_tmo_clr),
        .i_inc (w_tmo_inc),
        .o_cnt (w_tmo_cnt)
    );

    sat_cnt #(.W(DLY_W)) u_dly_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_dly_clr),
        .i_inc (w_dly_inc),
        .o_cnt (w_dly_cnt)
    );

    // Halt requests arriving mid-resume are remembered until RESUME is left.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend <= 1'b0;
        end else if (w_enter) begin
            r_pend <= 1'b0;
        end else if ((r_state == ST_RESUME) && halt_req_i) begin
            r_pend <= 1'b1;
        end else begin
            r_pend <= r_pend;
        end
    end

    // Output registers, loaded from the next state so they line up with state_o.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_halt_flag  <= `HoldDisable;
            r_halted     <= 1'b0;
            r_halt_ack   <= 1'b0;
            r_resume_ack <= 1'b0;
            r_tmo_err    <= 1'b0;
        end else begin
            r_halt_flag  <= ((w_next == ST_REQ) || (w_next == ST_HALTED)) ? `HoldEnable : `HoldDisable;
            r_halted     <= (w_next == ST_HALTED);
            r_halt_ack   <= w_halt_done;
            r_resume_ack <= w_resume_done;
            if (w_timeout) begin
                r_tmo_err <= 1'b1;
            end else if ((r_state == ST_IDLE) && halt_req_i) begin
                r_tmo_err <= 1'b0;
            end else begin
                r_tmo_err <= r_tmo_err;
            end
        end
    end

    assign halt_flag_o   = r_halt_flag;
    assign halted_o      = r_halted;
    assign halt_ack_o    = r_halt_ack;
    assign resume_ack_o  = r_resume_ack;
    assign timeout_err_o = r_tmo_err;
    assign state_o       = r_state;

endmodule
